boot_mem_loader: RTL and testbench

BOOT_MEM_LOADER -- requirements
Module: boot_mem_loader

---
 rtl/boot_mem_loader_pkg.sv | 34 +++
 rtl/boot_word_packer.sv | 64 ++++++
 rtl/boot_mem_loader.sv | 158 +++++++++++++++
 tb/tb_boot_mem_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// boot_mem_loader_pkg
// Shared types and constants for the boot image loader.
//   state_t          : loader FSM states
//   WORD_W           : memory word width in bits
//   BYTES_PER_WORD   : bytes packed into one memory word
//   LANE_W           : width of the byte-lane index
//   lane_strobe()    : write strobe covering lanes 0..lane inclusive
// ---------------------------------------------------------------------------
package boot_mem_loader_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } state_t;

    function automatic logic [BYTES_PER_WORD-1:0] lane_strobe(input logic [LANE_W-1:0] lane);
        logic [BYTES_PER_WORD-1:0] strb;
        strb = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (i <= int'(lane)) begin
                strb[i] = 1'b1;
            end
        end
        return strb;
    endfunction

endpackage

// File: rtl/boot_word_packer.sv
// ---------------------------------------------------------------------------
// boot_word_packer
// Packs an accepted little-endian byte stream into 32-bit words and issues a
// registered one-cycle write for every full word, or for a partial word when
// the byte carries the last flag.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : clears the partial word and byte lane (new image)
//   accept     : a byte is taken this cycle
//   data, last : accepted byte and end-of-image flag
//   flush      : combinational, the accepted byte completes a word this cycle
//   we, wdata, wstrb : registered write, valid the cycle after flush
// ---------------------------------------------------------------------------
module boot_word_packer
    import boot_mem_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      accept,
    input  logic [7:0]                data,
    input  logic                      last,
    output logic                      flush,
    output logic                      we,
    output logic [WORD_W-1:0]         wdata,
    output logic [BYTES_PER_WORD-1:0] wstrb
);

    logic [LANE_W-1:0] lane;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_nxt;

    // Partial word with the incoming byte merged into its lane; lanes above
    // the current one are still zero because word_q is cleared after a flush.
    always_comb begin
        word_nxt = word_q;
        word_nxt[{lane, 3'b000} +: 8] = data;
    end

    assign flush = accept && ((&lane) || last);

    always_ff @(posedge clk) begin
        if (rst) begin
            lane   <= '0;
            word_q <= '0;
            we     <= 1'b0;
            wdata  <= '0;
            wstrb  <= '0;
        end else begin
            we    <= flush;
            wstrb <= flush ? lane_strobe(lane) : '0;
            if (flush) begin
                wdata <= word_nxt;
            end
            if (clr) begin
                lane   <= '0;
                word_q <= '0;
            end else if (accept) begin
                lane   <= flush ? '0 : lane + 1'b1;
                word_q <= flush ? '0 : word_nxt;
            end
        end
    end

endmodule

// File: rtl/boot_mem_loader.sv
// ---------------------------------------------------------------------------
// boot_mem_loader
// Streams a firmware image (bytes, valid/ready) into a word-addressed memory
// and holds the CPU in reset until a complete image has been written.
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle request to (re)load an image
//   s_data, s_valid, s_ready, s_last : byte stream, s_last on final byte
//   mem_we, mem_addr, mem_wdata, mem_wstrb : memory write port
//   cpu_rst         : core reset, released only while a valid image is held
//   busy, done, err : loading / image ready / image overflowed memory
//   checksum        : sum of written words (BOOT_MEM_LOADER_CHECKSUM_EN only)
//
// Optional feature macro: BOOT_MEM_LOADER_CHECKSUM_EN
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, no image, CPU held in reset
// LOAD  | accepting bytes; one extra cycle after s_last for the final write
// RUN   | image complete, CPU released
// ERR   | image exceeded MEM_WORDS, CPU held in reset
// ---------------------------------------------------------------------------
module boot_mem_loader
    import boot_mem_loader_pkg::*;
#(
    parameter  int MEM_WORDS = 4096,
    localparam int AW        = $clog2(MEM_WORDS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7:0]                s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic                      s_last,
    output logic                      mem_we,
    output logic [AW-1:0]             mem_addr,
    output logic [WORD_W-1:0]         mem_wdata,
    output logic [BYTES_PER_WORD-1:0] mem_wstrb,
    output logic                      cpu_rst,
    output logic                      busy,
    output logic                      done,
    output logic                      err
`ifdef BOOT_MEM_LOADER_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0]         checksum
`endif
);

    // word_addr is one bit wider than mem_addr so it can reach MEM_WORDS,
    // which is what marks an image too large for the memory.
    localparam logic [AW:0] ADDR_LIMIT = (AW+1)'(MEM_WORDS);

    state_t      state;
    state_t      state_nxt;
    logic [AW:0] word_addr;
    logic        fin_pend;
    logic        accept;
    logic        overflow;
    logic        pk_accept;
    logic        pk_flush;
    logic        load_entry;

    assign accept     = s_valid && s_ready;
    assign overflow   = accept && (word_addr == ADDR_LIMIT);
    assign pk_accept  = accept && !overflow;
    assign load_entry = start && (state != LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RUN, ERR: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (overflow) begin
                    state_nxt = ERR;
                end else if (fin_pend) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // While fin_pend is high the final word is on the write port; the stream
    // is closed for that cycle so no byte of a following image slips in.
    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        cpu_rst = 1'b1;
        case (state)
            LOAD: begin
                s_ready = !fin_pend;
                busy    = 1'b1;
            end
            RUN: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
            end
            ERR: begin
                err = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || load_entry) begin
            word_addr <= '0;
            mem_addr  <= '0;
            fin_pend  <= 1'b0;
        end else begin
            if (pk_flush) begin
                mem_addr  <= word_addr[AW-1:0];
                word_addr <= word_addr + 1'b1;
            end
            fin_pend <= pk_accept && s_last;
        end
    end

    boot_word_packer u_packer (
        .clk    (clk),
        .rst    (rst),
        .clr    (load_entry),
        .accept (pk_accept),
        .data   (s_data),
        .last   (s_last),
        .flush  (pk_flush),
        .we     (mem_we),
        .wdata  (mem_wdata),
        .wstrb  (mem_wstrb)
    );

`ifdef BOOT_MEM_LOADER_CHECKSUM_EN
    // Accumulates from the registered write port, so the last word is added
    // on the cycle RUN is entered and the value is then frozen.
    always_ff @(posedge clk) begin
        if (rst || load_entry) begin
            checksum <= '0;
        end else if (mem_we) begin
            checksum <= checksum + mem_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_boot_mem_loader.sv
module tb_boot_mem_loader;

    localparam int MW = 4;
    localparam int AW = $clog2(MW);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          err;
`ifdef BOOT_MEM_LOADER_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    boot_mem_loader #(.MEM_WORDS(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef BOOT_MEM_LOADER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // write log captured away from the active edge
    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];
    logic [3:0]    ws_q[$];
    int            wc_q[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            ws_q.push_back(mem_wstrb);
            wc_q.push_back(cyc);
        end
    end

    typedef struct {
        int          n;
        logic [63:0] bytes;
        bit          rnd_gap;
        int          nw;
        logic [31:0] d0;
        logic [3:0]  s0;
        logic [31:0] d1;
        logic [3:0]  s1;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        ws_q.delete();
        wc_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        s_data  = b;
        s_last  = last;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (s_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL s_ready_timeout actual=%b required=1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        int n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        dc = cyc;
        chk("done_seen", done, 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cpu_rst"}, cpu_rst, 1);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
`ifdef BOOT_MEM_LOADER_CHECKSUM_EN
        chk({tag, "_checksum"}, checksum, 0);
`endif
    endtask

    task automatic run_case(input int idx);
        vec_t        v;
        int          dc;
        logic [31:0] exp_d;
        logic [3:0]  exp_s;
        logic [31:0] exp_sum;
        v = vecs[idx];
        clear_log();
        pulse_start();
        chk($sformatf("v%0d_busy_load", idx), busy, 1);
        chk($sformatf("v%0d_cpu_rst_load", idx), cpu_rst, 1);
        chk($sformatf("v%0d_done_load", idx), done, 0);
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.bytes[8*i +: 8], i == v.n - 1);
            if (v.rnd_gap && i < v.n - 1) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
            end
        end
        wait_done(dc);
        chk($sformatf("v%0d_nwrites", idx), wa_q.size(), v.nw);
        for (int k = 0; k < v.nw; k++) begin
            if (k < wa_q.size()) begin
                exp_d = (k == 0) ? v.d0 : v.d1;
                exp_s = (k == 0) ? v.s0 : v.s1;
                chk($sformatf("v%0d_wr%0d_addr", idx, k), wa_q[k], k);
                chk($sformatf("v%0d_wr%0d_data", idx, k), wd_q[k], exp_d);
                chk($sformatf("v%0d_wr%0d_strb", idx, k), ws_q[k], exp_s);
            end
        end
        if (wc_q.size() > 0) begin
            chk($sformatf("v%0d_done_timing", idx), dc, wc_q[wc_q.size()-1] + 1);
        end
        chk($sformatf("v%0d_cpu_rst_run", idx), cpu_rst, 0);
        chk($sformatf("v%0d_busy_run", idx), busy, 0);
        chk($sformatf("v%0d_s_ready_run", idx), s_ready, 0);
        chk($sformatf("v%0d_err_run", idx), err, 0);
        exp_sum = v.d0 + ((v.nw > 1) ? v.d1 : 32'h0);
`ifdef BOOT_MEM_LOADER_CHECKSUM_EN
        chk($sformatf("v%0d_checksum", idx), checksum, exp_sum);
        @(negedge clk);
        chk($sformatf("v%0d_checksum_stable", idx), checksum, exp_sum);
`endif
        if (exp_sum == 32'hFFFF_FFFF) begin
            $display("note: unusual checksum value in vector %0d", idx);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc;

        vecs[0] = '{n: 8, bytes: 64'h0807060504030201, rnd_gap: 1'b0, nw: 2,
                    d0: 32'h04030201, s0: 4'hF, d1: 32'h08070605, s1: 4'hF};
        vecs[1] = '{n: 5, bytes: 64'h000000EEDDCCBBAA, rnd_gap: 1'b0, nw: 2,
                    d0: 32'hDDCCBBAA, s0: 4'hF, d1: 32'h000000EE, s1: 4'b0001};
        vecs[2] = '{n: 8, bytes: 64'h0807060504030201, rnd_gap: 1'b1, nw: 2,
                    d0: 32'h04030201, s0: 4'hF, d1: 32'h08070605, s1: 4'hF};
        vecs[3] = '{n: 1, bytes: 64'h000000000000005A, rnd_gap: 1'b0, nw: 1,
                    d0: 32'h0000005A, s0: 4'b0001, d1: 32'h0, s1: 4'h0};
        vecs[4] = '{n: 3, bytes: 64'h0000000000332211, rnd_gap: 1'b0, nw: 1,
                    d0: 32'h00332211, s0: 4'b0111, d1: 32'h0, s1: 4'h0};
        vecs[5] = '{n: 4, bytes: 64'h00000000C4C3C2C1, rnd_gap: 1'b1, nw: 1,
                    d0: 32'hC4C3C2C1, s0: 4'hF, d1: 32'h0, s1: 4'h0};
        vecs[6] = '{n: 7, bytes: 64'h0070605040302010, rnd_gap: 1'b1, nw: 2,
                    d0: 32'h40302010, s0: 4'hF, d1: 32'h00706050, s1: 4'b0111};

        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cpu_rst", cpu_rst, 1);

        // start together with a valid byte in IDLE: that byte must be dropped
        clear_log();
        start   = 1'b1;
        s_valid = 1'b1;
        s_last  = 1'b1;
        s_data  = 8'h99;
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("sv_busy", busy, 1);
        chk("sv_s_ready", s_ready, 1);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        wait_done(dc);
        chk("sv_nwrites", wa_q.size(), 1);
        if (wd_q.size() > 0) begin
            chk("sv_wr0_data", wd_q[0], 32'h44332211);
            chk("sv_wr0_strb", ws_q[0], 4'hF);
            chk("sv_wr0_addr", wa_q[0], 0);
        end

        for (int i = 0; i < 7; i++) begin
            run_case(i);
        end

        // overflow: 17 bytes into a 4-word memory
        clear_log();
        pulse_start();
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i + 1), 1'b0);
        end
        chk("ovf_err", err, 1);
        chk("ovf_s_ready", s_ready, 0);
        chk("ovf_cpu_rst", cpu_rst, 1);
        chk("ovf_busy", busy, 0);
        chk("ovf_done", done, 0);
        repeat (5) @(negedge clk);
        chk("ovf_nwrites", wa_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < wa_q.size()) begin
                chk($sformatf("ovf_wr%0d_addr", k), wa_q[k], k);
                chk($sformatf("ovf_wr%0d_data", k), wd_q[k],
                    {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)});
            end
        end
        chk("ovf_err_held", err, 1);

        // reset in the middle of a load
        clear_log();
        pulse_start();
        chk("mid_err_cleared", err, 0);
        chk("mid_busy", busy, 1);
        for (int i = 0; i < 6; i++) begin
            send_byte(8'(i + 1), 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_nwrites", wa_q.size(), 1);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_idle_cpu_rst", cpu_rst, 1);
        run_case(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
